// File: rtl/led_band_pkg.sv
// Shared definitions for the LED-band grayscale shift path.
// Holds the sequencer state type and width helpers. The SOUT mux also uses
// these helpers so that both blocks agree on the padded word width.
package led_band_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT
    } state_t;

    // Width of the word actually shifted out: colour sample plus zero LSB padding.
    function automatic int unsigned word_width(int unsigned color_bits, int unsigned added_lsbs);
        return color_bits + added_lsbs;
    endfunction

    // Index width for n items. It never returns 0, so a degenerate n=1 still
    // gives a legal one-bit vector.
    function automatic int unsigned idx_width(int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_band_gs_sequencer.sv
// LED-band grayscale frame sequencer.
// On start, this block walks every colour word of one band frame in address
// order. For each word it issues a one-cycle RAM read (FETCH). It then presents
// the padded word to the SOUT mux MSB-first, two cycles per bit (SHIFT), with
// sclk low in the first cycle and high in the second. lat is raised over the
// final bits of the last colour word of each LED. The final LED uses a longer
// span.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start     - 1-cycle frame request, accepted only while idle
//   busy      - frame in progress
//   done      - 1-cycle pulse after the last bit of the frame
//   r_en      - frame RAM read strobe (1-cycle read latency)
//   r_addr    - frame RAM word address, led*NB_COLORS + color
//   bit_sel   - bit index into the padded word for the SOUT mux
//   sclk, lat - driver shift clock and latch
module led_band_gs_sequencer
    import led_band_pkg::*;
#(
    parameter int unsigned COLOR_DATA_WIDTH  = 8,
    parameter int unsigned NB_ADDED_LSB_BITS = 1,
    parameter int unsigned NB_COLORS         = 3,
    parameter int unsigned NB_LEDS           = 16,
    parameter int unsigned WRTGS_LEN         = 1,
    parameter int unsigned LATGS_LEN         = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic r_en,
    output logic [idx_width(NB_LEDS*NB_COLORS)-1:0] r_addr,
    output logic [idx_width(word_width(COLOR_DATA_WIDTH, NB_ADDED_LSB_BITS))-1:0] bit_sel,
    output logic sclk,
    output logic lat
);

    localparam int unsigned WW = word_width(COLOR_DATA_WIDTH, NB_ADDED_LSB_BITS);
    localparam int unsigned AW = idx_width(NB_LEDS*NB_COLORS);
    localparam int unsigned BW = idx_width(WW);
    localparam int unsigned CW = idx_width(NB_COLORS);
    localparam int unsigned LW = idx_width(NB_LEDS);

    state_t          state, state_nx;
    logic [CW-1:0]   color, color_nx;
    logic [LW-1:0]   led, led_nx;
    logic            busy_nx, done_nx, r_en_nx, sclk_nx, lat_nx;
    logic [AW-1:0]   r_addr_nx;
    logic [BW-1:0]   bit_sel_nx;
    logic            last_color, last_led;

    // bit_sel counts down from WW-1, so "the last N bits" means bit_sel < N.
    function automatic logic lat_for(logic [BW-1:0] bs, logic lc, logic ll);
        int unsigned span;
        span = ll ? LATGS_LEN : WRTGS_LEN;
        return lc && (32'(bs) < span);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            color   <= '0;
            led     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            r_en    <= 1'b0;
            r_addr  <= '0;
            bit_sel <= '0;
            sclk    <= 1'b0;
            lat     <= 1'b0;
        end else begin
            state   <= state_nx;
            color   <= color_nx;
            led     <= led_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            r_en    <= r_en_nx;
            r_addr  <= r_addr_nx;
            bit_sel <= bit_sel_nx;
            sclk    <= sclk_nx;
            lat     <= lat_nx;
        end
    end

    // The next-cycle values of every output are computed here and then
    // registered. As a result, each output reflects the state it belongs to
    // in the same cycle.
    always_comb begin
        state_nx   = state;
        color_nx   = color;
        led_nx     = led;
        busy_nx    = 1'b0;
        done_nx    = 1'b0;
        r_en_nx    = 1'b0;
        r_addr_nx  = r_addr;
        bit_sel_nx = bit_sel;
        sclk_nx    = 1'b0;
        lat_nx     = 1'b0;
        last_color = (color == CW'(NB_COLORS - 1));
        last_led   = (led == LW'(NB_LEDS - 1));

        unique case (state)
            IDLE: begin
                // done is still high in the first idle cycle; a start seen
                // in that cycle belongs to the frame just finished.
                if (start && !done) begin
                    state_nx  = FETCH;
                    busy_nx   = 1'b1;
                    r_en_nx   = 1'b1;
                    r_addr_nx = '0;
                    color_nx  = '0;
                    led_nx    = '0;
                end
            end
            FETCH: begin
                state_nx   = SHIFT;
                busy_nx    = 1'b1;
                bit_sel_nx = BW'(WW - 1);
                lat_nx     = lat_for(BW'(WW - 1), last_color, last_led);
            end
            SHIFT: begin
                busy_nx = 1'b1;
                if (!sclk) begin
                    sclk_nx = 1'b1;
                    lat_nx  = lat;
                end else if (bit_sel != '0) begin
                    bit_sel_nx = bit_sel - 1'b1;
                    lat_nx     = lat_for(bit_sel - 1'b1, last_color, last_led);
                end else if (last_color && last_led) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else begin
                    state_nx  = FETCH;
                    r_en_nx   = 1'b1;
                    r_addr_nx = r_addr + 1'b1;
                    if (last_color) begin
                        color_nx = '0;
                        led_nx   = led + 1'b1;
                    end else begin
                        color_nx = color + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_led_band_gs_sequencer.sv
// Self-checking bench for led_band_gs_sequencer with a 1-cycle RAM model and
// the SOUT bit-select mux. Expected values come from per-cycle arithmetic on
// the frame timing (19 cycles per word: 1 fetch + 9 bits x 2 phases).
module tb_led_band_gs_sequencer;

    localparam int WW   = 9;
    localparam int NW   = 48;
    localparam int CPW  = 1 + 2*WW;
    localparam int FLEN = NW*CPW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, r_en, sclk, lat;
    logic [5:0] r_addr;
    logic [3:0] bit_sel;

    logic [7:0]    mem [NW];
    logic [7:0]    q;
    logic [WW-1:0] padded;
    logic          sout;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    led_band_gs_sequencer #(
        .COLOR_DATA_WIDTH (8),
        .NB_ADDED_LSB_BITS(1),
        .NB_COLORS        (3),
        .NB_LEDS          (16),
        .WRTGS_LEN        (1),
        .LATGS_LEN        (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .r_en   (r_en),
        .r_addr (r_addr),
        .bit_sel(bit_sel),
        .sclk   (sclk),
        .lat    (lat)
    );

    always_ff @(posedge clk) if (r_en) q <= mem[r_addr];
    assign padded = {q, 1'b0};
    assign sout   = padded[bit_sel];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < NW; i++) mem[i] = 8'($urandom);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_ren"}, 32'(r_en), 0);
        check({tag, "_sclk"}, 32'(sclk), 0);
        check({tag, "_lat"}, 32'(lat), 0);
        check({tag, "_addr"}, 32'(r_addr), 0);
        check({tag, "_bitsel"}, 32'(bit_sel), 0);
    endtask

    // Called at the falling edge of cycle 1 of a frame (start sampled at
    // cycle 0). It checks every cycle through cycle FLEN+1 (the done cycle).
    // If abort_at > 0, it asserts rst at that cycle and checks the immediate
    // clear.
    task automatic frame_check(input int abort_at, input bit restart);
        int r1, r2, rises;
        logic prev_sclk;
        r1 = $urandom_range(2, FLEN);
        r2 = $urandom_range(2, FLEN);
        rises = 0;
        prev_sclk = 1'b0;
        for (int t = 1; t <= FLEN + 1; t++) begin
            if (t == abort_at) begin
                start = 1'b0;
                rst = 1'b1;
                #1;
                check_idle_zero("async_rst");
                return;
            end
            if (t <= FLEN) begin
                int w, p, b, ph, span;
                logic [WW-1:0] pw;
                w = (t - 1) / CPW;
                p = (t - 1) % CPW;
                check("busy", 32'(busy), 1);
                check("done", 32'(done), 0);
                check("addr", 32'(r_addr), 32'(w));
                if (p == 0) begin
                    check("ren_fetch", 32'(r_en), 1);
                    check("sclk_fetch", 32'(sclk), 0);
                    check("lat_fetch", 32'(lat), 0);
                end else begin
                    b  = (p - 1) / 2;
                    ph = (p - 1) % 2;
                    span = (w / 3 == 15) ? 3 : 1;
                    pw = {mem[w], 1'b0};
                    check("ren_shift", 32'(r_en), 0);
                    check("sclk", 32'(sclk), 32'(ph));
                    check("bitsel", 32'(bit_sel), 32'(WW - 1 - b));
                    check("lat", 32'(lat), 32'((w % 3 == 2) && (b >= WW - span)));
                    if (ph == 1) check("sout", 32'(sout), 32'(pw[WW-1-b]));
                end
            end else begin
                check("end_done", 32'(done), 1);
                check("end_busy", 32'(busy), 0);
                check("end_ren", 32'(r_en), 0);
                check("end_sclk", 32'(sclk), 0);
                check("end_lat", 32'(lat), 0);
            end
            if (sclk && !prev_sclk) rises++;
            prev_sclk = sclk;
            start = (t == 5 || t == 400 || t == FLEN + 1 || t == r1 || t == r2);
            @(negedge clk);
        end
        check("sclk_rises", 32'(rises), 32'(NW*WW));
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
        check("idle_ren", 32'(r_en), 0);
        fill_mem();
        start = restart;
        @(negedge clk);
    endtask

    initial begin
        fill_mem();
        mem[0] = 8'hA5;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("post_reset");

        start = 1'b1;
        @(negedge clk);
        frame_check(-1, 1'b1);
        frame_check(-1, 1'b0);

        start = 1'b1;
        @(negedge clk);
        frame_check(300, 1'b0);
        @(negedge clk);
        check_idle_zero("held_reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("after_abort");

        start = 1'b1;
        @(negedge clk);
        frame_check(-1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
